accumulator_win: RTL and testbench

- Parametrised successor of the team's free-running accumulator.
- Sums DATA_W-bit unsigned samples over a fixed window of WIN_LEN accepted samples.
- At the end of each window it emits the window sum with a one-cycle valid pulse and an overflow flag, then restarts automatically with no gap cycle.
- Per-sample overflow handling is selectable: saturate or wrap.
- Sits between unary/binary sample producers (counters, bitstream decoders) and downstream consumers that need windowed sums.

---
 rtl/accumulator_win.sv | 79 +++++++
 tb/tb_accumulator_win.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_win.sv
// rtl/accumulator_win.sv - windowed unsigned sample accumulator with wrap/saturate overflow
// Emits each window sum with a one-cycle valid pulse and restarts with no gap cycle.
module accumulator_win #(
  parameter int DATA_W  = 8,
  parameter int ACC_W   = 10,
  parameter int WIN_LEN = 8
) (
  input  logic              iClk,
  input  logic              iRstN,
  input  logic              iEn,
  input  logic              iClr,
  input  logic              iMode,
  input  logic [DATA_W-1:0] iData,
  output logic [ACC_W-1:0]  oAcc,
  output logic [ACC_W-1:0]  oData,
  output logic              oValid,
  output logic              oOvf
);

  localparam int CNT_W = $clog2(WIN_LEN + 1);
  localparam int SUM_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN_LEN - 1);

  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wovf;
  logic [ACC_W-1:0] r_data;
  logic             r_valid;
  logic             r_ovf;

  logic [SUM_W-1:0] w_sum;
  logic             w_add_ovf;
  logic [ACC_W-1:0] w_result;
  logic             w_last;

  // One extra bit of headroom exposes the carry-out as the per-sample overflow.
  assign w_sum     = {1'b0, r_acc} + SUM_W'(iData);
  assign w_add_ovf = w_sum[ACC_W];
  assign w_result  = (w_add_ovf && iMode) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
  assign w_last    = (r_cnt == LAST_CNT);

  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_wovf  <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (iClr) begin
        r_acc  <= '0;
        r_cnt  <= '0;
        r_wovf <= 1'b0;
      end else if (iEn) begin
        if (w_last) begin
          // Publish the completed window and start the next one on the following edge.
          r_data  <= w_result;
          r_ovf   <= r_wovf | w_add_ovf;
          r_valid <= 1'b1;
          r_acc   <= '0;
          r_cnt   <= '0;
          r_wovf  <= 1'b0;
        end else begin
          r_acc  <= w_result;
          r_cnt  <= r_cnt + CNT_W'(1);
          r_wovf <= r_wovf | w_add_ovf;
        end
      end
    end
  end

  assign oAcc   = r_acc;
  assign oData  = r_data;
  assign oValid = r_valid;
  assign oOvf   = r_ovf;

endmodule

// File: tb/tb_accumulator_win.sv
// tb/tb_accumulator_win.sv - self-checking bench for accumulator_win against an integer window model
module tb_accumulator_win;

  localparam int DATA_W  = 8;
  localparam int ACC_W   = 10;
  localparam int WIN_LEN = 8;
  localparam int MAXV    = (1 << ACC_W) - 1;

  logic              iClk = 1'b0;
  logic              iRstN;
  logic              iEn;
  logic              iClr;
  logic              iMode;
  logic [DATA_W-1:0] iData;
  logic [ACC_W-1:0]  oAcc;
  logic [ACC_W-1:0]  oData;
  logic              oValid;
  logic              oOvf;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: plain integers for the window sum and sample count.
  int m_acc, m_cnt, m_wovf, m_data, m_ovf, m_valid;

  accumulator_win #(.DATA_W(DATA_W), .ACC_W(ACC_W), .WIN_LEN(WIN_LEN)) dut (
    .iClk(iClk), .iRstN(iRstN), .iEn(iEn), .iClr(iClr), .iMode(iMode), .iData(iData),
    .oAcc(oAcc), .oData(oData), .oValid(oValid), .oOvf(oOvf)
  );

  always #5 iClk = ~iClk;

  task automatic model_reset();
    m_acc = 0; m_cnt = 0; m_wovf = 0; m_data = 0; m_ovf = 0; m_valid = 0;
  endtask

  function automatic logic [2*ACC_W+1:0] exp_vec();
    logic [ACC_W-1:0] a, d;
    a = m_acc[ACC_W-1:0];
    d = m_data[ACC_W-1:0];
    return {a, d, m_valid[0], m_ovf[0]};
  endfunction

  // Drive one cycle, advance the model by the window rules, return sampled 1ns after the edge.
  task automatic cycle(input logic en, input logic clr, input logic mode, input int data);
    int s, r, o;
    iEn = en; iClr = clr; iMode = mode; iData = data[DATA_W-1:0];
    @(posedge iClk);
    m_valid = 0;
    if (clr) begin
      m_acc = 0; m_cnt = 0; m_wovf = 0;
    end else if (en) begin
      s = m_acc + (data & ((1 << DATA_W) - 1));
      o = (s > MAXV) ? 1 : 0;
      r = o ? (mode ? MAXV : s - (MAXV + 1)) : s;
      if (m_cnt == WIN_LEN - 1) begin
        m_data = r; m_ovf = m_wovf | o; m_valid = 1;
        m_acc = 0; m_cnt = 0; m_wovf = 0;
      end else begin
        m_acc = r; m_cnt = m_cnt + 1; m_wovf = m_wovf | o;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    iRstN = 1'b0; iEn = 1'b0; iClr = 1'b0; iMode = 1'b0; iData = '0;
    model_reset();
    #12;
    n_tests++;
    if ({oAcc, oData, oValid, oOvf} !== '0) begin
      n_fail++;
      $display("FAIL reset: acc=%0d data=%0d valid=%0d ovf=%0d, want all 0", oAcc, oData, oValid, oOvf);
    end
    iRstN = 1'b1;
    #4;
  endtask

  task automatic test_steady();
    int pulses = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 10);
      n_tests++;
      if ({oAcc, oData, oValid, oOvf} !== exp_vec()) begin
        n_fail++;
        $display("FAIL steady[%0d]: acc=%0d data=%0d v=%0d ovf=%0d want %0d %0d %0d %0d",
                 i, oAcc, oData, oValid, oOvf, m_acc, m_data, m_valid, m_ovf);
      end
      if (oValid) begin
        pulses++;
        n_tests++;
        if (oData !== 10'd80 || oOvf !== 1'b0 || (i != 7 && i != 15)) begin
          n_fail++;
          $display("FAIL steady_pulse[%0d]: data=%0d ovf=%0d, want 80 0 at edges 8/16", i, oData, oOvf);
        end
      end
    end
    n_tests++;
    if (pulses != 2) begin
      n_fail++;
      $display("FAIL steady_count: got %0d pulses, want 2", pulses);
    end
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b1, 200);
      if (i == 4) begin
        n_tests++;
        if (oAcc !== 10'd1000) begin
          n_fail++;
          $display("FAIL sat_acc5: got %0d, want 1000", oAcc);
        end
      end
      if (i == 5 || i == 6) begin
        n_tests++;
        if (oAcc !== 10'd1023) begin
          n_fail++;
          $display("FAIL sat_hold[%0d]: got %0d, want 1023", i, oAcc);
        end
      end
    end
    n_tests++;
    if (oValid !== 1'b1 || oData !== 10'd1023 || oOvf !== 1'b1 || oAcc !== '0) begin
      n_fail++;
      $display("FAIL sat_out: v=%0d data=%0d ovf=%0d acc=%0d, want 1 1023 1 0", oValid, oData, oOvf, oAcc);
    end
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b1, 1);
    n_tests++;
    if (oValid !== 1'b1 || oData !== 10'd8 || oOvf !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_next: v=%0d data=%0d ovf=%0d, want 1 8 0", oValid, oData, oOvf);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 200);
    n_tests++;
    if (oValid !== 1'b1 || oData !== 10'd576 || oOvf !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap: v=%0d data=%0d ovf=%0d, want 1 576 1", oValid, oData, oOvf);
    end
  endtask

  task automatic test_en_toggle();
    int pulses = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'((i % 2) == 0), 1'b0, 1'b0, 5);
      if (oValid) begin
        pulses++;
        n_tests++;
        if (i != 14 || oData !== 10'd40 || oOvf !== 1'b0) begin
          n_fail++;
          $display("FAIL toggle_pulse: edge %0d data=%0d ovf=%0d, want edge 15 data 40 ovf 0", i + 1, oData, oOvf);
        end
      end
    end
    n_tests++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL toggle_count: got %0d pulses, want 1", pulses);
    end
  endtask

  task automatic test_clear();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 7);
    cycle(1'b1, 1'b1, 1'b0, 7);
    n_tests++;
    if (oAcc !== '0 || oValid !== 1'b0 || oData !== 10'd40) begin
      n_fail++;
      $display("FAIL clear: acc=%0d v=%0d data=%0d, want 0 0 40", oAcc, oValid, oData);
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 7);
      n_tests++;
      if ({oAcc, oData, oValid, oOvf} !== exp_vec()) begin
        n_fail++;
        $display("FAIL clear_win[%0d]: acc=%0d data=%0d v=%0d want %0d %0d %0d",
                 i, oAcc, oData, oValid, m_acc, m_data, m_valid);
      end
    end
    n_tests++;
    if (oValid !== 1'b1 || oData !== 10'd56) begin
      n_fail++;
      $display("FAIL clear_out: v=%0d data=%0d, want 1 56", oValid, oData);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 1'b0, 9);
    cycle(1'b1, 1'b0, 1'b0, 9);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 9);
    #2;
    iRstN = 1'b0;
    #1;
    n_tests++;
    if ({oAcc, oData, oValid, oOvf} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: acc=%0d data=%0d v=%0d ovf=%0d, want all 0", oAcc, oData, oValid, oOvf);
    end
    model_reset();
    #1;
    iRstN = 1'b1;
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 3);
    n_tests++;
    if (oValid !== 1'b1 || oData !== 10'd24 || oOvf !== 1'b0) begin
      n_fail++;
      $display("FAIL async_after: v=%0d data=%0d ovf=%0d, want 1 24 0", oValid, oData, oOvf);
    end
  endtask

  task automatic test_random();
    int d;
    for (int i = 0; i < 400; i++) begin
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(120, 255));
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), d);
      n_tests++;
      if ({oAcc, oData, oValid, oOvf} !== exp_vec()) begin
        n_fail++;
        $display("FAIL random[%0d]: acc=%0d data=%0d v=%0d ovf=%0d want %0d %0d %0d %0d",
                 i, oAcc, oData, oValid, oOvf, m_acc, m_data, m_valid, m_ovf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_saturate();
    test_wrap();
    test_en_toggle();
    test_clear();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
